// File: rtl/latency_reorder_buffer.sv
// Reorder buffer that holds each transaction for a programmable number of cycles
// and releases it either strictly in order or oldest-ready-first.
module latency_reorder_buffer #(
  parameter int NUM_TRANSACTIONS = 8,
  parameter int HDR_WIDTH        = 80,
  parameter int DATA_WIDTH       = 512,
  parameter int LAT_WIDTH        = 8,
  parameter int INORDER          = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [HDR_WIDTH-1:0]                meta_in,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic [LAT_WIDTH-1:0]                lat_in,
  input  logic                                valid_in,
  input  logic                                read_en,
  output logic [HDR_WIDTH-1:0]                meta_out,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic [$clog2(NUM_TRANSACTIONS)-1:0] tag_out,
  output logic                                valid_out,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(NUM_TRANSACTIONS):0]   count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int TAG_W = $clog2(NUM_TRANSACTIONS);
  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0]            wr_ptr, rd_ptr, occ;
  logic [TAG_W-1:0]            wr_idx, rd_idx, sel_idx, scan_idx;
  logic [NUM_TRANSACTIONS-1:0] live, ready;
  logic [LAT_WIDTH-1:0]        cd       [NUM_TRANSACTIONS];
  logic [HDR_WIDTH-1:0]        meta_mem [NUM_TRANSACTIONS];
  logic [DATA_WIDTH-1:0]       data_mem [NUM_TRANSACTIONS];
  logic                        sel_found, do_wr, do_pop, rd_adv;

  assign wr_idx = wr_ptr[TAG_W-1:0];
  assign rd_idx = rd_ptr[TAG_W-1:0];
  assign occ    = wr_ptr - rd_ptr;
  assign full   = (occ == PTR_W'(NUM_TRANSACTIONS));
  assign empty  = (count == '0);

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
      ready[i] = live[i] && (cd[i] == '0);
    end
  end

  // Slot selection: head only when in-order, otherwise the oldest ready slot
  // between rd_ptr and wr_ptr.
  always_comb begin
    sel_idx   = rd_idx;
    sel_found = 1'b0;
    scan_idx  = rd_idx;
    if (INORDER != 0) begin
      sel_found = ready[rd_idx];
    end else begin
      for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
        scan_idx = rd_idx + TAG_W'(i);
        if (!sel_found && (PTR_W'(i) < occ) && ready[scan_idx]) begin
          sel_found = 1'b1;
          sel_idx   = scan_idx;
        end
      end
    end
  end

  assign valid_out = sel_found;
  assign tag_out   = sel_idx;
  assign meta_out  = meta_mem[sel_idx];
  assign data_out  = data_mem[sel_idx];

  assign do_wr  = valid_in && !full;
  assign do_pop = valid_out && read_en;
  // Head moves past holes left by out-of-order pops, one slot per cycle.
  assign rd_adv = (rd_ptr != wr_ptr) &&
                  (!live[rd_idx] || (do_pop && (sel_idx == rd_idx)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      live      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
        cd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
        if (live[i] && (cd[i] != '0)) begin
          cd[i] <= cd[i] - LAT_WIDTH'(1);
        end
      end
      if (do_pop) begin
        live[sel_idx] <= 1'b0;
      end
      if (do_wr) begin
        live[wr_idx] <= 1'b1;
        cd[wr_idx]   <= lat_in;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
      if (valid_in && full) begin
        overflow <= 1'b1;
      end
      if (read_en && !valid_out) begin
        underflow <= 1'b1;
      end
    end
  end

  // Payload storage is never reset; live bits alone decide visibility.
  always_ff @(posedge clk) begin
    if (do_wr && !rst) begin
      meta_mem[wr_idx] <= meta_in;
      data_mem[wr_idx] <= data_in;
    end
  end

endmodule
